// File: rtl/bp_ethernet_nbf_decoder.sv
// NBF record parser: turns an Ethernet byte stream into uncached I/O writes
// with credit tracking, fence and finish handling.
module bp_ethernet_nbf_decoder #(
  parameter int paddr_width_p     = 40,
  parameter int max_outstanding_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_v_i,
  input  logic                     rx_last_i,
  output logic                     rx_ready_and_o,
  output logic [paddr_width_p-1:0] cmd_addr_o,
  output logic [63:0]              cmd_data_o,
  output logic [1:0]               cmd_size_o,
  output logic                     cmd_v_o,
  input  logic                     cmd_yumi_i,
  input  logic                     resp_v_i,
  output logic                     resp_ready_and_o,
  output logic                     done_o,
  output logic                     error_o
);

  localparam int cnt_w = $clog2(max_outstanding_p + 1);
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(max_outstanding_p);

  localparam logic [2:0] s_opcode = 3'd0;
  localparam logic [2:0] s_addr   = 3'd1;
  localparam logic [2:0] s_data   = 3'd2;
  localparam logic [2:0] s_issue  = 3'd3;
  localparam logic [2:0] s_fence  = 3'd4;
  localparam logic [2:0] s_done   = 3'd5;

  logic [2:0]               state_q;
  logic [2:0]               idx_q;
  logic [7:0]               opc_q;
  logic [cnt_w-1:0]         cnt_q;
  logic [paddr_width_p-1:0] addr_d;
  logic [5:0]               pos;

  logic rx_fire, cmd_fire, last_byte;
  logic opc_wr, opc_fin, parse_err, spur_err;

  assign rx_ready_and_o   = (state_q == s_opcode)
                          | (state_q == s_addr)
                          | (state_q == s_data);
  assign cmd_v_o          = (state_q == s_issue) && (cnt_q < cnt_max);
  assign done_o           = (state_q == s_done);
  assign resp_ready_and_o = 1'b1;

  assign rx_fire   = rx_v_i & rx_ready_and_o;
  assign cmd_fire  = cmd_v_o & cmd_yumi_i;
  assign last_byte = (state_q == s_data) && (idx_q == 3'd7);
  assign opc_wr    = (opc_q == 8'h03) || (opc_q == 8'h02);
  assign opc_fin   = (opc_q == 8'hFE) || (opc_q == 8'hFF);
  assign parse_err = rx_fire & (last_byte ? !(opc_wr | opc_fin) : rx_last_i);
  assign spur_err  = resp_v_i & !cmd_fire & (cnt_q == '0);

  // Address bytes beyond the physical width are dropped bit by bit.
  always_comb begin
    addr_d = cmd_addr_o;
    pos    = '0;
    for (int b = 0; b < 8; b++) begin
      pos = {idx_q, 3'(b)};
      if (int'(pos) < paddr_width_p)
        addr_d[pos] = rx_data_i[b];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else if (cmd_fire && !resp_v_i) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (!cmd_fire && resp_v_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      error_o <= 1'b0;
    else if (parse_err || spur_err)
      error_o <= 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= s_opcode;
      idx_q      <= '0;
      opc_q      <= '0;
      cmd_addr_o <= '0;
      cmd_data_o <= '0;
      cmd_size_o <= '0;
    end else begin
      unique case (state_q)
        s_opcode: if (rx_fire) begin
          opc_q   <= rx_data_i;
          idx_q   <= '0;
          state_q <= rx_last_i ? s_opcode : s_addr;
        end
        s_addr: if (rx_fire) begin
          cmd_addr_o <= addr_d;
          idx_q      <= idx_q + 1'b1;
          if (rx_last_i)
            state_q <= s_opcode;
          else if (idx_q == 3'd7)
            state_q <= s_data;
        end
        s_data: if (rx_fire) begin
          cmd_data_o[{idx_q, 3'b000} +: 8] <= rx_data_i;
          idx_q <= idx_q + 1'b1;
          if (last_byte) begin
            if (opc_wr) begin
              state_q    <= s_issue;
              cmd_size_o <= (opc_q == 8'h03) ? 2'd3 : 2'd2;
              if (opc_q == 8'h02)
                cmd_data_o[63:32] <= '0;
            end else if (opc_fin) begin
              state_q <= s_fence;
            end else begin
              state_q <= s_opcode;
            end
          end else if (rx_last_i) begin
            state_q <= s_opcode;
          end
        end
        s_issue: if (cmd_fire) state_q <= s_opcode;
        s_fence: if (cnt_q == '0)
          state_q <= (opc_q == 8'hFF) ? s_done : s_opcode;
        s_done: state_q <= s_done;
        default: state_q <= s_opcode;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_ethernet_nbf_decoder.sv
// Directed self-checking bench for bp_ethernet_nbf_decoder
// (credit limit of 2 so back-pressure is reachable).
module tb_bp_ethernet_nbf_decoder;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_v_i = 1'b0;
  logic        rx_last_i = 1'b0;
  logic        rx_ready_and_o;
  logic [39:0] cmd_addr_o;
  logic [63:0] cmd_data_o;
  logic [1:0]  cmd_size_o;
  logic        cmd_v_o;
  logic        cmd_yumi_i = 1'b0;
  logic        resp_v_i = 1'b0;
  logic        resp_ready_and_o;
  logic        done_o;
  logic        error_o;

  int checks = 0;
  int failures = 0;

  bp_ethernet_nbf_decoder #(
    .paddr_width_p(40),
    .max_outstanding_p(2)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .rx_data_i(rx_data_i),
    .rx_v_i(rx_v_i),
    .rx_last_i(rx_last_i),
    .rx_ready_and_o(rx_ready_and_o),
    .cmd_addr_o(cmd_addr_o),
    .cmd_data_o(cmd_data_o),
    .cmd_size_o(cmd_size_o),
    .cmd_v_o(cmd_v_o),
    .cmd_yumi_i(cmd_yumi_i),
    .resp_v_i(resp_v_i),
    .resp_ready_and_o(resp_ready_and_o),
    .done_o(done_o),
    .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic apply_reset();
    rx_v_i = 0; rx_last_i = 0; cmd_yumi_i = 0; resp_v_i = 0;
    reset_n_i = 0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1;
    @(posedge clk_i); #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    rx_data_i = d; rx_last_i = last; rx_v_i = 1;
    while (!rx_ready_and_o && n < 100) begin
      @(posedge clk_i); #1; n++;
    end
    if (!rx_ready_and_o) begin
      checks++; failures++;
      $display("FAIL send_byte_timeout: rx_ready_and_o=%b required 1", rx_ready_and_o);
    end else begin
      @(posedge clk_i); #1;
    end
    rx_v_i = 0; rx_last_i = 0;
  endtask

  task automatic send_record(input logic [7:0] opc, input logic [63:0] a,
                             input logic [63:0] d, input int trunc_at);
    logic [135:0] rec;
    rec = {d, a, opc};
    for (int i = 0; i < 17; i++) begin
      send_byte(rec[8*i +: 8], (i == 16) || (i == trunc_at));
      if (i == trunc_at) break;
    end
  endtask

  task automatic do_yumi();
    int n = 0;
    while (!cmd_v_o && n < 100) begin
      @(posedge clk_i); #1; n++;
    end
    checks++;
    if (!cmd_v_o) begin
      failures++;
      $display("FAIL yumi_timeout: cmd_v_o=%b required 1", cmd_v_o);
    end else begin
      cmd_yumi_i = 1;
      @(posedge clk_i); #1;
      cmd_yumi_i = 0;
    end
  endtask

  task automatic do_resp();
    resp_v_i = 1;
    @(posedge clk_i); #1;
    resp_v_i = 0;
  endtask

  task automatic test_reset();
    reset_n_i = 0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({rx_ready_and_o, cmd_v_o, done_o, error_o, resp_ready_and_o} !== 5'b10001) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 10001",
               {rx_ready_and_o, cmd_v_o, done_o, error_o, resp_ready_and_o});
    end
    checks++;
    if ({cmd_addr_o, cmd_data_o, cmd_size_o} !== '0) begin
      failures++;
      $display("FAIL reset_cmd: addr=%h data=%h size=%0d required 0",
               cmd_addr_o, cmd_data_o, cmd_size_o);
    end
    reset_n_i = 1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_write8();
    send_record(8'h03, 64'h0000_0080_0000_1000, 64'h1122334455667788, -1);
    checks++;
    if (cmd_v_o !== 1'b1 || rx_ready_and_o !== 1'b0) begin
      failures++;
      $display("FAIL w8_latency: cmd_v=%b rx_ready=%b required 1 0", cmd_v_o, rx_ready_and_o);
    end
    checks++;
    if (cmd_addr_o !== 40'h80_0000_1000 || cmd_size_o !== 2'd3) begin
      failures++;
      $display("FAIL w8_addr: addr=%h size=%0d required 8000001000 3", cmd_addr_o, cmd_size_o);
    end
    checks++;
    if (cmd_data_o !== 64'h1122334455667788) begin
      failures++;
      $display("FAIL w8_data: got %h required 1122334455667788", cmd_data_o);
    end
    do_yumi();
    checks++;
    if (rx_ready_and_o !== 1'b1 || cmd_v_o !== 1'b0) begin
      failures++;
      $display("FAIL w8_after_yumi: rx_ready=%b cmd_v=%b required 1 0", rx_ready_and_o, cmd_v_o);
    end
    do_resp();
  endtask

  task automatic test_write4();
    send_record(8'h02, 64'hFFFF_FF12_3456_7890, 64'hDDCCBBAA_EEEEEEEE, -1);
    checks++;
    if (cmd_v_o !== 1'b1 || cmd_size_o !== 2'd2) begin
      failures++;
      $display("FAIL w4_size: cmd_v=%b size=%0d required 1 2", cmd_v_o, cmd_size_o);
    end
    checks++;
    if (cmd_data_o !== 64'h00000000_EEEEEEEE) begin
      failures++;
      $display("FAIL w4_data: got %h required 00000000eeeeeeee", cmd_data_o);
    end
    checks++;
    if (cmd_addr_o !== 40'h12_3456_7890) begin
      failures++;
      $display("FAIL w4_addr_trunc: got %h required 1234567890", cmd_addr_o);
    end
    do_yumi();
    do_resp();
  endtask

  task automatic test_credit_stall();
    send_record(8'h03, 64'hA000, 64'h1, -1);
    do_yumi();
    send_record(8'h03, 64'hB000, 64'h2, -1);
    checks++;
    if (cmd_v_o !== 1'b1) begin
      failures++;
      $display("FAIL credit_second: cmd_v=%b required 1", cmd_v_o);
    end
    do_yumi();
    send_record(8'h03, 64'hC000, 64'h3, -1);
    repeat (4) @(posedge clk_i); #1;
    checks++;
    if (cmd_v_o !== 1'b0 || rx_ready_and_o !== 1'b0) begin
      failures++;
      $display("FAIL credit_stall: cmd_v=%b rx_ready=%b required 0 0", cmd_v_o, rx_ready_and_o);
    end
    do_resp();
    checks++;
    if (cmd_v_o !== 1'b1 || cmd_addr_o !== 40'hC000) begin
      failures++;
      $display("FAIL credit_release: cmd_v=%b addr=%h required 1 c000", cmd_v_o, cmd_addr_o);
    end
    do_yumi();
  endtask

  task automatic test_fence_finish();
    send_record(8'hFE, 64'h0, 64'h0, -1);
    repeat (3) @(posedge clk_i); #1;
    checks++;
    if (rx_ready_and_o !== 1'b0) begin
      failures++;
      $display("FAIL fence_hold2: rx_ready=%b required 0", rx_ready_and_o);
    end
    do_resp();
    @(posedge clk_i); #1;
    checks++;
    if (rx_ready_and_o !== 1'b0) begin
      failures++;
      $display("FAIL fence_hold1: rx_ready=%b required 0", rx_ready_and_o);
    end
    do_resp();
    checks++;
    if (rx_ready_and_o !== 1'b0) begin
      failures++;
      $display("FAIL fence_exit_early: rx_ready=%b required 0", rx_ready_and_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (rx_ready_and_o !== 1'b1) begin
      failures++;
      $display("FAIL fence_exit: rx_ready=%b required 1", rx_ready_and_o);
    end
    send_record(8'hFF, 64'h0, 64'h0, -1);
    checks++;
    if (done_o !== 1'b0 || rx_ready_and_o !== 1'b0) begin
      failures++;
      $display("FAIL finish_fence: done=%b rx_ready=%b required 0 0", done_o, rx_ready_and_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (done_o !== 1'b1) begin
      failures++;
      $display("FAIL finish_done: done=%b required 1", done_o);
    end
    rx_v_i = 1; rx_data_i = 8'h03;
    repeat (5) @(posedge clk_i); #1;
    rx_v_i = 0;
    checks++;
    if ({done_o, rx_ready_and_o, cmd_v_o, error_o} !== 4'b1000) begin
      failures++;
      $display("FAIL done_sticky: got %b required 1000",
               {done_o, rx_ready_and_o, cmd_v_o, error_o});
    end
  endtask

  task automatic check_recovery(input string tag, input logic [39:0] a, input logic [63:0] d);
    checks++;
    if (error_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_error: error_o=%b required 1", tag, error_o);
    end
    send_record(8'h03, {24'h0, a}, d, -1);
    checks++;
    if (cmd_v_o !== 1'b1 || cmd_addr_o !== a || cmd_data_o !== d) begin
      failures++;
      $display("FAIL %s_recover: cmd_v=%b addr=%h data=%h required 1 %h %h",
               tag, cmd_v_o, cmd_addr_o, cmd_data_o, a, d);
    end
    do_yumi();
    do_resp();
  endtask

  task automatic test_errors();
    apply_reset();
    checks++;
    if (error_o !== 1'b0) begin
      failures++;
      $display("FAIL err_cleared: error_o=%b required 0", error_o);
    end
    send_record(8'h03, 64'h5555, 64'h5555, 5);
    checks++;
    if (rx_ready_and_o !== 1'b1 || cmd_v_o !== 1'b0) begin
      failures++;
      $display("FAIL trunc_state: rx_ready=%b cmd_v=%b required 1 0", rx_ready_and_o, cmd_v_o);
    end
    check_recovery("trunc", 40'h00_0000_2000, 64'hCAFEBABE_01020304);

    apply_reset();
    send_record(8'h7A, 64'h1234, 64'h5678, -1);
    checks++;
    if (rx_ready_and_o !== 1'b1 || cmd_v_o !== 1'b0) begin
      failures++;
      $display("FAIL unknown_drop: rx_ready=%b cmd_v=%b required 1 0", rx_ready_and_o, cmd_v_o);
    end
    check_recovery("unknown", 40'h01_0000_3000, 64'h0F0E0D0C0B0A0908);

    apply_reset();
    do_resp();
    check_recovery("spurious", 40'hFF_FFFF_FFF8, 64'hFFFFFFFF_00000001);
  endtask

  task automatic test_reset_in_issue();
    apply_reset();
    send_record(8'h03, 64'h100, 64'h1, -1);
    do_yumi();
    send_record(8'h03, 64'h200, 64'h2, -1);
    checks++;
    if (cmd_v_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_issue_pre: cmd_v=%b required 1", cmd_v_o);
    end
    reset_n_i = 0;
    #1;
    checks++;
    if (cmd_v_o !== 1'b0 || rx_ready_and_o !== 1'b1 || cmd_addr_o !== '0) begin
      failures++;
      $display("FAIL rst_async: cmd_v=%b rx_ready=%b addr=%h required 0 1 0",
               cmd_v_o, rx_ready_and_o, cmd_addr_o);
    end
    @(negedge clk_i);
    reset_n_i = 1;
    @(posedge clk_i); #1;
    send_record(8'h03, 64'h300, 64'h3, -1);
    do_yumi();
    send_record(8'h03, 64'h400, 64'h4, -1);
    checks++;
    if (cmd_v_o !== 1'b1 || cmd_addr_o !== 40'h400 || cmd_data_o !== 64'h4) begin
      failures++;
      $display("FAIL rst_counter: cmd_v=%b addr=%h data=%h required 1 400 4",
               cmd_v_o, cmd_addr_o, cmd_data_o);
    end
    do_yumi();
  endtask

  initial begin
    test_reset();
    test_write8();
    test_write4();
    test_credit_stall();
    test_fence_finish();
    test_errors();
    test_reset_in_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
